// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// uart_rx_ctrl : UART receive frame controller (start/data/parity/stop)
// Revision     : 1.0
// ------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RX_IN,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic [5:0]        Prescale,
  input  logic              sampled_bit,
  output logic              data_samp_en,
  output logic [5:0]        edge_cnt,
  output logic [5:0]        samp_prescale,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state_q,  state_d;
  logic [5:0]        edge_q,   edge_d;
  logic [BW-1:0]     bit_q,    bit_d;
  logic [DATA_W-1:0] shift_q,  shift_d;
  logic [5:0]        presc_q,  presc_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              ferr_q,   ferr_d;
  logic [DATA_W-1:0] pdata_q,  pdata_d;
  logic              valid_q,  valid_d;
  logic              perr_q,   perr_d;
  logic              serr_q,   serr_d;
  logic              w_bit_end;

  // ">=" rather than "==" so an illegal tiny Prescale still ends the bit
  assign w_bit_end = (edge_q >= (presc_q - 6'd1));

  always_comb begin
    state_d   = state_q;
    edge_d    = edge_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    presc_d   = presc_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    ferr_d    = ferr_q;
    pdata_d   = pdata_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    serr_d    = 1'b0;

    if (state_q == S_IDLE) begin
      edge_d = 6'd0;
      if (!RX_IN) begin
        state_d   = S_START;
        edge_d    = 6'd1;
        bit_d     = '0;
        presc_d   = Prescale;
        par_en_d  = PAR_EN;
        par_typ_d = PAR_TYP;
        ferr_d    = 1'b0;
      end
    end else begin
      edge_d = w_bit_end ? 6'd0 : edge_q + 6'd1;
      if (w_bit_end) begin
        case (state_q)
          S_START: state_d = sampled_bit ? S_IDLE : S_DATA;
          S_DATA: begin
            shift_d = {sampled_bit, shift_q[DATA_W-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP;
          end
          S_PARITY: begin
            if (sampled_bit != (^shift_q ^ par_typ_q)) begin
              perr_d = 1'b1;
              ferr_d = 1'b1;
            end
            state_d = S_STOP;
          end
          S_STOP: begin
            serr_d = ~sampled_bit;
            if (sampled_bit && !ferr_q) begin
              valid_d = 1'b1;
              pdata_d = shift_q;
            end
            ferr_d  = 1'b0;
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      edge_q    <= 6'd0;
      bit_q     <= '0;
      shift_q   <= '0;
      presc_q   <= 6'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      ferr_q    <= 1'b0;
      pdata_q   <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      ferr_q    <= ferr_d;
      pdata_q   <= pdata_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      serr_q    <= serr_d;
    end
  end

  assign data_samp_en  = (state_q != S_IDLE);
  assign edge_cnt      = edge_q;
  assign samp_prescale = presc_q;
  assign P_DATA        = pdata_q;
  assign data_valid    = valid_q;
  assign par_err       = perr_q;
  assign stp_err       = serr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_uart_rx_ctrl : frame-level model bench for uart_rx_ctrl
// Revision        : 1.0
// ------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       sampled_bit;
  logic       data_samp_en;
  logic [5:0] edge_cnt;
  logic [5:0] samp_prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  // Ideal sampler: the line is constant across each bit
  assign sampled_bit = RX_IN;

  uart_rx_ctrl #(.DATA_W(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .Prescale(Prescale), .sampled_bit(sampled_bit), .data_samp_en(data_samp_en),
    .edge_cnt(edge_cnt), .samp_prescale(samp_prescale), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         d;       // edge index of the detect cycle
    int         p;
    int         len;     // frame length in cycles
    int         perr_e;  // edge index after which par_err shows, -1 if none
    bit         valid;
    bit         serr;
    logic [7:0] data;
  } frame_t;

  frame_t frames[$];
  int cyc  = 0;
  int vec  = 0;
  int miss = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Frame-level model: each recorded frame implies a busy window and end pulses
  always @(negedge CLK) begin
    logic       en, dv, pe, se;
    logic [5:0] ec, sp;
    logic [7:0] pd;
    int e;
    e = cyc;
    en = 0; dv = 0; pe = 0; se = 0; ec = 0; sp = 0; pd = 0;
    foreach (frames[i]) begin
      if (e >= frames[i].d) sp = 6'(frames[i].p);
      if (e >= frames[i].d && e <= frames[i].d + frames[i].len - 2) begin
        en = 1;
        ec = 6'((e - frames[i].d + 1) % frames[i].p);
      end
      if (e == frames[i].d + frames[i].len - 1) begin
        dv = frames[i].valid;
        se = frames[i].serr;
      end
      if (e == frames[i].perr_e) pe = 1;
      if (frames[i].valid && e >= frames[i].d + frames[i].len - 1) pd = frames[i].data;
    end
    vec++;
    if ({data_samp_en, edge_cnt, samp_prescale, P_DATA, data_valid, par_err, stp_err} !==
        {en, ec, sp, pd, dv, pe, se}) begin
      miss++;
      $display("FAIL cycle %0d: got en=%b ec=%0d sp=%0d pd=%h dv=%b pe=%b se=%b, expected en=%b ec=%0d sp=%0d pd=%h dv=%b pe=%b se=%b",
               e, data_samp_en, edge_cnt, samp_prescale, P_DATA, data_valid, par_err, stp_err,
               en, ec, sp, pd, dv, pe, se);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drives a frame starting on the next edge; nbits>0 stops after that many bits
  task automatic send_frame(input int p, input logic [7:0] d, input bit pe, input bit pt,
                            input bit pb, input bit sb, input int nbits = 0);
    bit     b[$];
    frame_t f;
    int     n;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pe) b.push_back(pb);
    b.push_back(sb);
    f.d      = cyc + 1;
    f.p      = p;
    f.len    = b.size() * p;
    f.data   = d;
    f.perr_e = (pe && (pb != (^d ^ pt))) ? f.d + 10 * p - 1 : -1;
    f.serr   = !sb;
    f.valid  = sb && (f.perr_e < 0);
    frames.push_back(f);
    Prescale = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    n = (nbits == 0) ? b.size() : nbits;
    for (int j = 0; j < n; j++) begin
      RX_IN = b[j];
      repeat (p) @(posedge CLK);
      #1;
      if (j == 0) begin
        Prescale = 6'd5;
        PAR_EN   = !pe;
        PAR_TYP  = !pt;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    frame_t g;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_en", {7'd0, data_samp_en}, 8'h00);
    chk("reset_pdata", P_DATA, 8'h00);
    RST = 1'b1;
    idle(3);

    // 1: plain frame
    send_frame(8, 8'hA5, 0, 0, 0, 1);
    chk("t1_valid", {7'd0, data_valid}, 8'h01);
    chk("t1_pdata", P_DATA, 8'hA5);
    chk("t1_stp", {7'd0, stp_err}, 8'h00);
    idle(4);

    // 2: even parity, wrong then right parity bit
    send_frame(8, 8'h3C, 1, 0, 1, 1);
    chk("t2_err_valid", {7'd0, data_valid}, 8'h00);
    chk("t2_err_pdata", P_DATA, 8'hA5);
    idle(2);
    send_frame(8, 8'h3C, 1, 0, 0, 1);
    chk("t2_ok_valid", {7'd0, data_valid}, 8'h01);
    chk("t2_ok_pdata", P_DATA, 8'h3C);
    idle(3);

    // 3: start-bit glitch
    g.d = cyc + 1; g.p = 8; g.len = 8; g.perr_e = -1; g.valid = 0; g.serr = 0; g.data = 8'h00;
    frames.push_back(g);
    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk("t3_en", {7'd0, data_samp_en}, 8'h00);
    chk("t3_pdata", P_DATA, 8'h3C);
    idle(5);

    // 4: stop error, then a break (line low), then recovery
    send_frame(16, 8'h81, 0, 0, 0, 0);
    chk("t4_stp", {7'd0, stp_err}, 8'h01);
    chk("t4_valid", {7'd0, data_valid}, 8'h00);
    send_frame(16, 8'h00, 0, 0, 0, 0);
    chk("t4_break_stp", {7'd0, stp_err}, 8'h01);
    send_frame(16, 8'h55, 0, 0, 0, 1);
    chk("t4_pdata", P_DATA, 8'h55);
    chk("t4_presc", {2'd0, samp_prescale}, 8'd16);
    idle(4);

    // 5: odd parity, back-to-back frames
    send_frame(16, 8'h12, 1, 1, 1, 1);
    chk("t5_a_pdata", P_DATA, 8'h12);
    send_frame(16, 8'hF0, 1, 1, 1, 1);
    chk("t5_b_valid", {7'd0, data_valid}, 8'h01);
    chk("t5_b_pdata", P_DATA, 8'hF0);
    idle(4);

    // 6: reset during data bit 4
    send_frame(8, 8'h6B, 0, 0, 0, 1, 5);
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    frames.delete();
    #1;
    chk("t6_rst_en", {7'd0, data_samp_en}, 8'h00);
    chk("t6_rst_ec", {2'd0, edge_cnt}, 8'h00);
    chk("t6_rst_pdata", P_DATA, 8'h00);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(3);
    send_frame(32, 8'h6B, 0, 0, 0, 1);
    chk("t6_pdata", P_DATA, 8'h6B);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
